// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
package mem_arb_pkg;
  localparam int NUM_MASTERS  = 2;
  localparam int RESP_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wr_req_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Master request/response port and the single-port memory port of the arbiter.
interface mem_arbiter_if #(parameter int AW = 12);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] addr;
  logic          wen;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          resp_valid;
  logic [31:0]   rdata;

  modport master (output req_valid, addr, wen, wdata, wstrb,
                  input  req_ready, resp_valid, rdata);
  modport slave  (input  req_valid, addr, wen, wdata, wstrb,
                  output req_ready, resp_valid, rdata);
endinterface

interface mem_arbiter_mem_if #(parameter int AW = 12);
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          wren;
  logic          rden;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic [31:0]   rdata;

  modport master (output waddr, raddr, wren, rden, wdata, wstrb, input rdata);
  modport slave  (input  waddr, raddr, wren, rden, wdata, wstrb, output rdata);
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the
// master that was not granted last. Output is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port synchronous-write,
// combinational-read memory. One transaction in flight: IDLE -> ACCESS -> RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input logic                clk,
  input logic                rst,
  mem_arbiter_if.slave       m0,
  mem_arbiter_if.slave       m1,
  mem_arbiter_mem_if.master  mem
);
  localparam int AW = ADDR_WIDTH - 2;

  state_e            state;
  logic              last_grant;
  logic              owner;
  logic [AW-1:0]     addr_q;
  wr_req_t           req_q;
  logic [31:0]       rdata_q;

  logic [NUM_MASTERS-1:0] valid;
  logic [NUM_MASTERS-1:0] grant;
  logic              idle;
  logic              hs;
  logic              access;

  assign valid = {m1.req_valid, m0.req_valid};

  rr_arb2 u_rr (
    .valid      (valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Gating with rst keeps ready low while reset holds the FSM in IDLE.
  assign idle         = (state == IDLE) && !rst;
  assign m0.req_ready = idle & grant[0];
  assign m1.req_ready = idle & grant[1];
  assign hs           = idle & (|grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      addr_q     <= '0;
      req_q      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (hs) begin
          state      <= ACCESS;
          last_grant <= grant[1];
          owner      <= grant[1];
          addr_q     <= grant[1] ? m1.addr : m0.addr;
          req_q      <= grant[1] ? '{m1.wen, m1.wdata, m1.wstrb}
                                 : '{m0.wen, m0.wdata, m0.wstrb};
        end
        ACCESS: begin
          state   <= RESP;
          // Writes respond with zero data so rdata never leaks a stale read.
          rdata_q <= req_q.wen ? 32'h0 : mem.rdata;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign access    = (state == ACCESS);
  assign mem.waddr = addr_q;
  assign mem.raddr = addr_q;
  assign mem.wren  = access &  req_q.wen;
  assign mem.rden  = access & ~req_q.wen;
  assign mem.wdata = req_q.wdata;
  assign mem.wstrb = req_q.wstrb;

  assign m0.resp_valid = (state == RESP) & ~owner;
  assign m1.resp_valid = (state == RESP) &  owner;
  assign m0.rdata      = rdata_q;
  assign m1.rdata      = rdata_q;

  logic hs0, hs1;
  assign hs0 = hs & grant[0];
  assign hs1 = hs & grant[1];

  a_excl_en: assert property (@(posedge clk) disable iff (rst) !(mem.wren && mem.rden));
  a_rdy_idle: assert property (@(posedge clk) disable iff (rst)
    (m0.req_ready || m1.req_ready) |-> (state == IDLE));
  a_resp0: assert property (@(posedge clk) disable iff (rst)
    m0.resp_valid |-> $past(hs0, RESP_LATENCY));
  a_resp1: assert property (@(posedge clk) disable iff (rst)
    m1.resp_valid |-> $past(hs1, RESP_LATENCY));
  a_one_resp: assert property (@(posedge clk) disable iff (rst)
    !(m0.resp_valid && m1.resp_valid));
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-strobed behavioural memory.
module tb_mem_arbiter;
  localparam int ADDR_WIDTH = 14;
  localparam int AW = ADDR_WIDTH - 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if     #(.AW(AW)) m0_if ();
  mem_arbiter_if     #(.AW(AW)) m1_if ();
  mem_arbiter_mem_if #(.AW(AW)) mem_if ();

  mem_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .mem (mem_if)
  );

  logic [1:0]    v;
  logic [AW-1:0] a  [2];
  logic          w  [2];
  logic [31:0]   wd [2];
  logic [3:0]    ws [2];

  assign m0_if.req_valid = v[0];
  assign m0_if.addr      = a[0];
  assign m0_if.wen       = w[0];
  assign m0_if.wdata     = wd[0];
  assign m0_if.wstrb     = ws[0];
  assign m1_if.req_valid = v[1];
  assign m1_if.addr      = a[1];
  assign m1_if.wen       = w[1];
  assign m1_if.wdata     = wd[1];
  assign m1_if.wstrb     = ws[1];

  wire [1:0] rdy = {m1_if.req_ready, m0_if.req_ready};
  wire [1:0] rv  = {m1_if.resp_valid, m0_if.resp_valid};

  logic [31:0] mem_arr [256];
  assign mem_if.rdata = mem_arr[mem_if.raddr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
    end else if (mem_if.wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_if.wstrb[b]) mem_arr[mem_if.waddr[7:0]][8*b +: 8] <= mem_if.wdata[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One isolated transaction from master m, checked cycle by cycle.
  task automatic xfer(input int m, input logic [AW-1:0] addr, input logic wen,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] exp_rd);
    @(negedge clk);
    v[m] = 1'b1; a[m] = addr; w[m] = wen; wd[m] = wdata; ws[m] = wstrb;
    #1;
    chk("ready_idle", rdy, (m == 0) ? 2'b01 : 2'b10);
    @(posedge clk); #1;
    v[m] = 1'b0; a[m] = '1; w[m] = ~wen; wd[m] = ~wdata; ws[m] = ~wstrb;
    @(negedge clk);
    chk("acc_wren", mem_if.wren, wen);
    chk("acc_rden", mem_if.rden, !wen);
    chk("acc_waddr", mem_if.waddr, addr);
    chk("acc_raddr", mem_if.raddr, addr);
    if (wen) begin
      chk("acc_wdata", mem_if.wdata, wdata);
      chk("acc_wstrb", mem_if.wstrb, wstrb);
    end
    chk("acc_rv", rv, 2'b00);
    chk("acc_rdy", rdy, 2'b00);
    @(negedge clk);
    chk("resp_rv", rv, (m == 0) ? 2'b01 : 2'b10);
    chk("resp_rdata", (m == 0) ? m0_if.rdata : m1_if.rdata, exp_rd);
    chk("resp_en", {mem_if.wren, mem_if.rden}, 2'b00);
    @(negedge clk);
    chk("post_rv", rv, 2'b00);
  endtask

  int hs_cyc[$];
  int hs_m[$];

  initial begin
    v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a[i] = '0; w[i] = 1'b0; wd[i] = '0; ws[i] = '0;
    end

    // Reset: requests present must not see ready.
    repeat (2) @(negedge clk);
    v = 2'b11; #1;
    chk("rst_ready", rdy, 2'b00);
    chk("rst_rv", rv, 2'b00);
    chk("rst_en", {mem_if.wren, mem_if.rden}, 2'b00);
    chk("rst_rdata0", m0_if.rdata, 32'h0);
    chk("rst_rdata1", m1_if.rdata, 32'h0);
    v = 2'b00;
    @(negedge clk); rst = 1'b0;

    xfer(0, 12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0);
    xfer(1, 12'h010, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF);
    xfer(0, 12'h020, 1'b1, 32'h11223344, 4'b0101, 32'h0);
    xfer(1, 12'h020, 1'b0, 32'h0, 4'h0, 32'h00220044);
    xfer(1, 12'h010, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0);
    xfer(0, 12'h010, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF);

    // Both masters requesting continuously from reset.
    @(negedge clk); rst = 1'b1;
    a[0] = 12'h001; w[0] = 1'b0; a[1] = 12'h002; w[1] = 1'b0;
    v = 2'b11;
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (rdy[0] && v[0]) begin hs_cyc.push_back(c); hs_m.push_back(0); end
      if (rdy[1] && v[1]) begin hs_cyc.push_back(c); hs_m.push_back(1); end
    end
    v = 2'b00;
    chk("rr_count", hs_m.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_master", (i < hs_m.size()) ? hs_m[i] : 99, i % 2);
      chk("rr_cycle", (i < hs_cyc.size()) ? hs_cyc[i] : 99, 3 * i);
    end
    repeat (3) @(negedge clk);

    // Reset during ACCESS of an m1 read aborts it.
    @(negedge clk);
    v[1] = 1'b1; a[1] = 12'h010; w[1] = 1'b0;
    @(posedge clk); #1; v[1] = 1'b0;
    @(negedge clk);
    chk("abort_rden", mem_if.rden, 1'b1);
    rst = 1'b1; #1;
    chk("abort_rst_en", {mem_if.wren, mem_if.rden}, 2'b00);
    chk("abort_rst_rv", rv, 2'b00);
    @(negedge clk);
    chk("abort_rv_hold", rv, 2'b00);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_rv", rv, 2'b00);
    end
    chk("abort_rdata", m1_if.rdata, 32'h0);
    v = 2'b11; #1;
    chk("abort_tie_m0", rdy, 2'b01);
    @(posedge clk); #1; v = 2'b00;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, byte-address width; word address is ADDR_WIDTH-2 bits (AW).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mN_req_valid  input  1  request from master N (N=0,1).
REQ-005 mN_req_ready  output  1  arbiter accepts master N request this cycle.
REQ-006 mN_addr  input  AW  word address.
REQ-007 mN_wen  input  1  1 = write, 0 = read.
REQ-008 mN_wdata  input  32  write data.
REQ-009 mN_wstrb  input  4  byte write strobes.
REQ-010 mN_resp_valid  output  1  one-cycle completion pulse to master N.
REQ-011 mN_rdata  output  32  read data, valid with mN_resp_valid.
REQ-012 mem_waddr, mem_raddr  output  AW  memory write/read word address.
REQ-013 mem_wren, mem_rden  output  1  memory write/read enables.
REQ-014 mem_wdata  output  32; mem_wstrb  output  4  memory write data/strobes.
REQ-015 mem_rdata  input  32  combinational memory read data.

Function
REQ-016 FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS on handshake, ACCESS->RESP always, RESP->IDLE always.
REQ-017 Handshake SHALL be mN_req_valid & mN_req_ready; mN_req_ready SHALL be asserted combinationally only in IDLE and only for the granted master.
REQ-018 Grant SHALL be round-robin: single requester wins; both valid -> master not granted last wins.
REQ-019 last_grant SHALL update only on handshake.
REQ-020 On handshake, addr, wen, wdata, wstrb and owner SHALL be latched; master may change inputs the next cycle.
REQ-021 In ACCESS, mem_waddr = mem_raddr = latched addr; mem_wren = wen; mem_rden = ~wen; mem_wdata/mem_wstrb = latched values.
REQ-022 mem_wren and mem_rden SHALL be 0 in IDLE and RESP.
REQ-023 In ACCESS on read, mem_rdata SHALL be captured into the response register.
REQ-024 In RESP, owner's mN_resp_valid SHALL be 1 for exactly one cycle; the other master's is 0.
REQ-025 Writes SHALL also get a resp_valid pulse, with mN_rdata = 0.
REQ-026 mN_rdata SHALL hold the last captured value outside RESP; it is meaningful only with resp_valid.
REQ-027 Latency: handshake cycle T, memory access T+1, resp_valid T+2; next handshake earliest T+3.
REQ-028 Writes with wstrb = 0 SHALL still issue mem_wren and respond.
REQ-029 Requests arriving in ACCESS/RESP SHALL wait; no request is dropped while valid is held.
REQ-030 No response backpressure; masters SHALL accept resp_valid unconditionally.

Reset
REQ-031 rst SHALL force IDLE, last_grant = 1 (m0 wins first tie), latched regs and rdata = 0.
REQ-032 During reset all ready, resp_valid and mem enables SHALL be 0.
REQ-033 Reset mid-transaction SHALL abort it with no response; a write in ACCESS may not complete.

Structure
REQ-034 Shared package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), NUM_MASTERS = 2 and RESP_LATENCY = 2.
REQ-035 Sub-module rr_arb2 SHALL implement the 2-input round-robin grant (inputs valid[1:0], last_grant; output grant[1:0], one-hot or zero).

Verification
REQ-036 m0 write addr 0x010, wdata 0xDEADBEEF, wstrb 4'hF -> mem_wren = 1 one cycle later with those values; m0_resp_valid at T+2.
REQ-037 m1 read addr 0x010 after that write, memory returning 0xDEADBEEF -> mem_rden at T+1; m1_resp_valid and m1_rdata = 0xDEADBEEF at T+2.
REQ-038 m0 and m1 both valid continuously from reset -> grants m0, m1, m0, m1, one handshake every 3 cycles.
REQ-039 Partial write wstrb 4'b0101, wdata 0x11223344 -> mem_wstrb = 4'b0101, mem_wdata = 0x11223344.
REQ-040 rst asserted in ACCESS of an m1 read -> no m1_resp_valid; after release, FSM in IDLE and a tie grants m0.
REQ-041 Assertions: one resp_valid per handshake; mem_wren & mem_rden never both 1; ready never asserted outside IDLE.
